inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, address of the first fetched instruction after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  hazard-unit hold; freezes PC and IF/ID outputs.
REQ-005 flush  input  1  kills the instruction being written into IF/ID this edge.
REQ-006 br_taken  input  1  redirect request from ID (branch/jump/jr resolved).
REQ-007 br_target  input  32  redirect byte address, valid with br_taken.
REQ-008 halt  input  1  syscall/halt pulse from ID; stops fetching.
REQ-009 ice  output  1  instruction-memory chip enable.
REQ-010 iaddr  output  32  instruction-memory byte address.
REQ-011 idata  input  32  instruction word, combinational from memory, same cycle as iaddr.
REQ-012 if_pc  output  32  IF/ID registered PC of if_inst.
REQ-013 if_inst  output  32  IF/ID registered instruction word.
REQ-014 if_valid  output  1  IF/ID entry holds a live instruction.
REQ-015 misalign_err  output  1  one-cycle pulse: redirect target with addr[1:0] != 0.

Function
REQ-016 State machine SHALL have states IDLE, RUN, HALT; IDLE->RUN on first edge after reset release; RUN->HALT on edge with halt=1; HALT exits only by reset.
REQ-017 ice SHALL be 1 only in RUN; iaddr SHALL equal pc in all states.
REQ-018 In RUN, edge with stall=0: if_pc<=pc, if_inst<=idata, if_valid<=1, pc<=next_pc.
REQ-019 next_pc priority: pending redirect target, else br_target if br_taken, else pc+4 (modulo 2^32, wrap from 32'hFFFF_FFFC to 0).
REQ-020 Branch delay slot SHALL be honoured: the instruction fetched in the cycle br_taken is seen is not killed by the redirect.
REQ-021 Edge with stall=1: pc and if_pc/if_inst/if_valid hold; br_taken SHALL be captured into a pending register (latest request wins).
REQ-022 Pending redirect SHALL be consumed on the first non-stalled RUN edge, then cleared.
REQ-023 flush=1 SHALL force if_valid<=0 and if_inst<=32'h0 at that edge, regardless of stall; pc still follows REQ-018/021.
REQ-024 Redirect target SHALL be loaded with bits [1:0] cleared; misalign_err SHALL pulse for exactly the cycle after the offending br_taken edge.
REQ-025 In IDLE and HALT: if_valid SHALL be 0, pc holds, br_taken ignored, pending cleared.
REQ-026 halt and br_taken on the same edge: halt wins; state HALT, no redirect.
REQ-027 Fetch latency: instruction at address A appears on if_inst one edge after iaddr=A with stall=0.

Reset
REQ-028 Asynchronous assert: pc=RESET_PC, state=IDLE, ice=0, if_pc=0, if_inst=0, if_valid=0, pending cleared, misalign_err=0.
REQ-029 Reset mid-operation (any state, any stall/pending) SHALL discard all in-flight state per REQ-028.

Structure
REQ-030 State encoding (IDLE/RUN/HALT), NOP word 32'h0 and RESET_PC default SHALL live in the shared CPU package.
REQ-031 Single natural sub-module: pc_reg (PC register plus pending-redirect register); IF/ID register and FSM in inst_fetch top.

Verification
REQ-032 Reset release, no stall, memory word i = i: if_pc sequence 0,4,8,... with if_inst 0,1,2,...; ice low first cycle only.
REQ-033 br_taken=1, br_target=32'h40 while pc=32'h10: next if_pc 32'h10 (delay slot, valid), then 32'h40.
REQ-034 stall=1 for 3 cycles with br_taken pulse target 32'h80 in cycle 2: outputs frozen 3 cycles, then if_pc 32'h80 sequence begins after current pc.
REQ-035 flush=1 with stall=1: if_valid=0, if_inst=0 next edge; pc unchanged.
REQ-036 br_target=32'h42: pc loads 32'h40, misalign_err high exactly one cycle.
REQ-037 halt pulse then br_taken: ice=0, if_valid=0 forever; rst_n low mid-run returns all outputs to reset values asynchronously.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared CPU fetch definitions: fetch FSM encoding, NOP word and default reset PC.
// Also provides the helper that word-aligns redirect targets.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// Program counter plus pending-redirect register.
// Redirects that arrive while stalled are parked here until the pipeline moves again.
module pc_reg
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic [31:0] pc_o,
    output logic        misalign_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        pend_valid_q, pend_valid_d;
    logic        misalign_q, misalign_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            pend_tgt_q   <= 32'h0;
            pend_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pend_tgt_q   <= pend_tgt_d;
            pend_valid_q <= pend_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        pend_tgt_d   = pend_tgt_q;
        pend_valid_d = pend_valid_q;
        misalign_d   = en_i && br_taken_i && (br_target_i[1:0] != 2'b00);

        if (!en_i) begin
            pend_valid_d = 1'b0;
        end else if (stall_i) begin
            if (br_taken_i) begin
                pend_valid_d = 1'b1;
                pend_tgt_d   = align_word(br_target_i);
            end
        end else begin
            // An older parked redirect outranks a fresh one; pc+4 wraps naturally at 32 bits.
            if (pend_valid_q)
                pc_d = pend_tgt_q;
            else if (br_taken_i)
                pc_d = align_word(br_target_i);
            else
                pc_d = pc_q + 32'd4;
            pend_valid_d = 1'b0;
        end
    end

    assign pc_o       = pc_q;
    assign misalign_o = misalign_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: IDLE/RUN/HALT fetch FSM, PC register and the IF/ID pipeline register.
// The instruction fetched alongside a taken branch is kept (branch delay slot).
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        halt,
    output logic        ice,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        misalign_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_inst_q, if_inst_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  pc;
    logic         fetch_en;
    logic         advance;

    // Halt outranks everything on its edge, so only a non-halting RUN edge fetches.
    assign fetch_en = (state_q == RUN) && !halt;
    assign advance  = fetch_en && !stall;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (fetch_en),
        .stall_i     (stall),
        .br_taken_i  (br_taken),
        .br_target_i (br_target),
        .pc_o        (pc),
        .misalign_o  (misalign_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            if_pc_q    <= 32'h0;
            if_inst_q  <= NOP_WORD;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;

        unique case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (halt) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if_pc_d    = pc;
            if_inst_d  = idata;
            if_valid_d = 1'b1;
        end else if (!fetch_en) begin
            if_valid_d = 1'b0;
        end

        if (flush) begin
            if_inst_d  = NOP_WORD;
            if_valid_d = 1'b0;
        end
    end

    assign ice      = (state_q == RUN);
    assign iaddr    = pc;
    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;
    assign if_valid = if_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Table-driven bench for inst_fetch: memory returns word index (addr>>2) as the instruction.
// Rows hold inputs for one edge and the outputs expected just after that edge.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        halt = 1'b0;
    logic        ice;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        misalign_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        brTaken;
        logic [31:0] brTarget;
        logic        halt;
        logic        expIce;
        logic [31:0] expIaddr;
        logic [31:0] expIfPc;
        logic [31:0] expIfInst;
        logic        expValid;
        logic        expMis;
    } vec_t;

    vec_t rows[$];

    inst_fetch #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .halt         (halt),
        .ice          (ice),
        .iaddr        (iaddr),
        .idata        (idata),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_valid     (if_valid),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    assign idata = {2'b00, iaddr[31:2]};

    task automatic addRow(input logic s, input logic f, input logic b, input logic [31:0] t,
                          input logic h, input logic eIce, input logic [31:0] eIaddr,
                          input logic [31:0] eIfPc, input logic [31:0] eIfInst,
                          input logic eValid, input logic eMis);
        vec_t v;
        v.stall = s; v.flush = f; v.brTaken = b; v.brTarget = t; v.halt = h;
        v.expIce = eIce; v.expIaddr = eIaddr; v.expIfPc = eIfPc; v.expIfInst = eIfInst;
        v.expValid = eValid; v.expMis = eMis;
        rows.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic eIce, input logic [31:0] eIaddr,
                            input logic [31:0] eIfPc, input logic [31:0] eIfInst,
                            input logic eValid, input logic eMis);
        checkOutput({tag, ".ice"}, {31'b0, ice}, {31'b0, eIce});
        checkOutput({tag, ".iaddr"}, iaddr, eIaddr);
        checkOutput({tag, ".if_pc"}, if_pc, eIfPc);
        checkOutput({tag, ".if_inst"}, if_inst, eIfInst);
        checkOutput({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, eValid});
        checkOutput({tag, ".misalign"}, {31'b0, misalign_err}, {31'b0, eMis});
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        stall = v.stall; flush = v.flush; br_taken = v.brTaken;
        br_target = v.brTarget; halt = v.halt;
        @(posedge clk);
        #1;
    endtask

    task automatic runRows(input string tag);
        foreach (rows[i]) begin
            applyStimulus(rows[i]);
            checkAll($sformatf("%s[%0d]", tag, i), rows[i].expIce, rows[i].expIaddr,
                     rows[i].expIfPc, rows[i].expIfInst, rows[i].expValid, rows[i].expMis);
        end
        rows.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;

        //     st fl br target        ht ice iaddr         if_pc         if_inst       v  mis
        addRow(0, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        32'h0,        0, 0);
        addRow(0, 0, 0, 32'h0,        0, 1, 32'h4,        32'h0,        32'h0,        1, 0);
        addRow(0, 0, 0, 32'h0,        0, 1, 32'h8,        32'h4,        32'h1,        1, 0);
        addRow(0, 0, 0, 32'h0,        0, 1, 32'hC,        32'h8,        32'h2,        1, 0);
        addRow(0, 0, 0, 32'h0,        0, 1, 32'h10,       32'hC,        32'h3,        1, 0);
        addRow(0, 0, 1, 32'h40,       0, 1, 32'h40,       32'h10,       32'h4,        1, 0);
        addRow(0, 0, 0, 32'h0,        0, 1, 32'h44,       32'h40,       32'h10,       1, 0);
        addRow(1, 0, 0, 32'h0,        0, 1, 32'h44,       32'h40,       32'h10,       1, 0);
        addRow(1, 0, 1, 32'h80,       0, 1, 32'h44,       32'h40,       32'h10,       1, 0);
        addRow(1, 0, 0, 32'h0,        0, 1, 32'h44,       32'h40,       32'h10,       1, 0);
        addRow(0, 0, 0, 32'h0,        0, 1, 32'h80,       32'h44,       32'h11,       1, 0);
        addRow(0, 0, 0, 32'h0,        0, 1, 32'h84,       32'h80,       32'h20,       1, 0);
        addRow(1, 1, 0, 32'h0,        0, 1, 32'h84,       32'h80,       32'h0,        0, 0);
        addRow(0, 0, 0, 32'h0,        0, 1, 32'h88,       32'h84,       32'h21,       1, 0);
        addRow(0, 1, 0, 32'h0,        0, 1, 32'h8C,       32'h88,       32'h0,        0, 0);
        addRow(0, 0, 1, 32'h42,       0, 1, 32'h40,       32'h8C,       32'h23,       1, 1);
        addRow(0, 0, 0, 32'h0,        0, 1, 32'h44,       32'h40,       32'h10,       1, 0);
        addRow(1, 0, 1, 32'h100,      0, 1, 32'h44,       32'h40,       32'h10,       1, 0);
        addRow(1, 0, 1, 32'h104,      0, 1, 32'h44,       32'h40,       32'h10,       1, 0);
        addRow(0, 0, 1, 32'h200,      0, 1, 32'h104,      32'h44,       32'h11,       1, 0);
        addRow(0, 0, 0, 32'h0,        0, 1, 32'h108,      32'h104,      32'h41,       1, 0);
        addRow(0, 0, 1, 32'h302,      1, 0, 32'h108,      32'h104,      32'h41,       0, 0);
        addRow(0, 0, 1, 32'h400,      0, 0, 32'h108,      32'h104,      32'h41,       0, 0);
        addRow(0, 0, 0, 32'h0,        0, 0, 32'h108,      32'h104,      32'h41,       0, 0);
        runRows("runA");

        // Asynchronous reset asserted between edges while halted.
        #2 rst_n = 1'b0;
        #1 checkAll("asyncResetHalt", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        addRow(0, 0, 1, 32'h501,      0, 1, 32'h0,        32'h0,        32'h0,        0, 0);
        addRow(0, 0, 1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 32'h0,      32'h0,        1, 0);
        addRow(0, 0, 0, 32'h0,        0, 1, 32'h0,        32'hFFFF_FFFC, 32'h3FFF_FFFF, 1, 0);
        addRow(0, 0, 0, 32'h0,        0, 1, 32'h4,        32'h0,        32'h0,        1, 0);
        addRow(1, 0, 1, 32'h600,      0, 1, 32'h4,        32'h0,        32'h0,        1, 0);
        runRows("runB");

        // Reset while stalled with a redirect parked: the parked target must be discarded.
        #2 rst_n = 1'b0;
        #1 checkAll("asyncResetPending", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        addRow(0, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        32'h0,        0, 0);
        addRow(0, 0, 0, 32'h0,        0, 1, 32'h4,        32'h0,        32'h0,        1, 0);
        addRow(0, 0, 0, 32'h0,        0, 1, 32'h8,        32'h4,        32'h1,        1, 0);
        runRows("runC");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
